// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB first, repeated reps times, then pulses done.
// Optional macro SEQ_GEN_TX_ABORT_EN adds an abort input that ends the frame early.
module seq_gen_tx #(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(6'b101010)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_def,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       reps,
`ifdef SEQ_GEN_TX_ABORT_EN
  input  logic             abort,
`endif
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       reps_q, reps_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sel;
  logic             abort_req;

`ifdef SEQ_GEN_TX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      reps_q  <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      reps_q  <= reps_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // sh_q holds the bits still to be sent in the current repetition, next bit at its MSB.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    reps_d  = reps_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sel     = use_def ? DEF_PATTERN : pattern;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = sel;
          sh_d    = sel << 1;
          x_d     = sel[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          reps_d  = (reps == 4'd0) ? 4'd1 : reps;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (abort_req) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == LAST_BIT) begin
          if (reps_q > 4'd1) begin
            reps_d  = reps_q - 4'd1;
            cnt_d   = '0;
            x_d     = pat_q[WIDTH-1];
            sh_d    = pat_q << 1;
            valid_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          x_d     = sh_q[WIDTH-1];
          sh_d    = sh_q << 1;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed self-checking bench for seq_gen_tx (default parameters).
module tb_seq_gen_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic       use_def;
  logic [5:0] pattern;
  logic [3:0] reps;
`ifdef SEQ_GEN_TX_ABORT_EN
  logic       abort;
`endif
  logic       x;
  logic       valid;
  logic       busy;
  logic       done;

  int checks;
  int passes;

  seq_gen_tx dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .use_def (use_def),
    .pattern (pattern),
    .reps    (reps),
`ifdef SEQ_GEN_TX_ABORT_EN
    .abort   (abort),
`endif
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bits(input string name, input logic [3:0] exp);
    checks++;
    if ({x, valid, busy, done} !== exp)
      $display("[TB] FAIL %s: x/valid/busy/done got %b expected %b", name, {x, valid, busy, done}, exp);
    else
      passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    check_bits("reset_outputs", 4'b0000);
    #10;
    reset = 1'b1;
  endtask

  task automatic test_default_pattern();
    logic [5:0] exp_pat;
    exp_pat = 6'b101010;
    start   = 1'b1;
    use_def = 1'b1;
    reps    = 4'd1;
    pattern = 6'b000000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = 1'b0;
      check_bits($sformatf("def_bit%0d", k), {exp_pat[6-k], 3'b110});
    end
    tick();
    check_bits("def_done", 4'b0011);
    tick();
    check_bits("def_idle", 4'b0000);
  endtask

  task automatic test_reps3();
    logic [17:0] exp_stream;
    exp_stream = 18'b110011110011110011;
    start   = 1'b1;
    use_def = 1'b0;
    pattern = 6'b110011;
    reps    = 4'd3;
    for (int k = 1; k <= 18; k++) begin
      tick();
      start   = 1'b0;
      pattern = 6'b000000;
      reps    = 4'd1;
      use_def = 1'b1;
      check_bits($sformatf("reps3_bit%0d", k), {exp_stream[18-k], 3'b110});
    end
    tick();
    check_bits("reps3_done", 4'b0011);
    tick();
    check_bits("reps3_idle", 4'b0000);
  endtask

  task automatic test_reps0_start_ignored();
    logic [5:0] exp_pat;
    exp_pat = 6'b100110;
    start   = 1'b1;
    use_def = 1'b0;
    pattern = exp_pat;
    reps    = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = (k == 3);
      check_bits($sformatf("reps0_bit%0d", k), {exp_pat[6-k], 3'b110});
    end
    start = 1'b0;
    tick();
    check_bits("reps0_done", 4'b0011);
    tick();
    check_bits("reps0_idle1", 4'b0000);
    tick();
    check_bits("reps0_idle2", 4'b0000);
  endtask

  task automatic test_reset_midframe();
    logic [5:0] exp_pat;
    exp_pat = 6'b101010;
    start   = 1'b1;
    use_def = 1'b1;
    reps    = 4'd2;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start = 1'b0;
    end
    check_bits("mid_bit4", {exp_pat[2], 3'b110});
    #2;
    reset = 1'b0;
    #1;
    check_bits("mid_async_clear", 4'b0000);
    tick();
    check_bits("mid_held_no_done", 4'b0000);
    #2;
    reset = 1'b1;
    tick();
    check_bits("mid_idle_after_release", 4'b0000);
    tick();
    check_bits("mid_idle_wait", 4'b0000);
    start = 1'b1;
    reps  = 4'd1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = 1'b0;
      check_bits($sformatf("mid_new_bit%0d", k), {exp_pat[6-k], 3'b110});
    end
    tick();
    check_bits("mid_new_done", 4'b0011);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_pat;
    logic [3:0] exp;
    int p;
    exp_pat = 6'b101010;
    start   = 1'b1;
    use_def = 1'b1;
    reps    = 4'd1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 20) start = 1'b0;
      p = (k - 1) % 8;
      if (p < 6)       exp = {exp_pat[5-p], 3'b110};
      else if (p == 6) exp = 4'b0011;
      else             exp = 4'b0000;
      check_bits($sformatf("b2b_cycle%0d", k), exp);
    end
  endtask

`ifdef SEQ_GEN_TX_ABORT_EN
  task automatic test_abort();
    start   = 1'b1;
    use_def = 1'b1;
    reps    = 4'd2;
    tick();
    start = 1'b0;
    check_bits("abort_bit0", 4'b1110);
    tick();
    check_bits("abort_bit1", 4'b0110);
    tick();
    check_bits("abort_bit2", 4'b1110);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_bits("abort_done", 4'b0011);
    tick();
    check_bits("abort_idle", 4'b0000);
  endtask
`endif

  initial begin
    checks  = 0;
    passes  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    use_def = 1'b0;
    pattern = 6'b000000;
    reps    = 4'd0;
`ifdef SEQ_GEN_TX_ABORT_EN
    abort   = 1'b0;
`endif
    test_reset();
    test_default_pattern();
    test_reps3();
    test_reps0_start_ignored();
    test_reset_midframe();
    test_back_to_back();
`ifdef SEQ_GEN_TX_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
